// File: rtl/blob_feature_accum.sv
// blob_feature_accum: accumulates per-label bounding box and area from the
// resolved CCL label stream over one frame, then streams one record per
// present label (ascending label order) through a valid/ready handshake.
// Optional build macro BLOB_CENTROID_EN adds per-label column/row sums.
module blob_feature_accum #(
  parameter int LABEL_W = 8,
  parameter int COL_W   = 14,
  parameter int ROW_W   = 12,
  parameter int AREA_W  = 26
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [LABEL_W-1:0]      labelin,
  input  logic                    frame_valid,
  input  logic                    data_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LABEL_W-1:0]      out_label,
  output logic [COL_W-1:0]        out_xmin,
  output logic [COL_W-1:0]        out_xmax,
  output logic [ROW_W-1:0]        out_ymin,
  output logic [ROW_W-1:0]        out_ymax,
  output logic [AREA_W-1:0]       out_area,
  output logic [COL_W+AREA_W-1:0] out_sumx,
  output logic [ROW_W+AREA_W-1:0] out_sumy,
  output logic                    frame_done,
  output logic                    err_overrun,
  output logic                    busy
);
  localparam int NLBL = 1 << LABEL_W;

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, READOUT, DONE} state_t;

  typedef struct packed {
    logic [COL_W-1:0]        xmin;
    logic [COL_W-1:0]        xmax;
    logic [ROW_W-1:0]        ymin;
    logic [ROW_W-1:0]        ymax;
    logic [AREA_W-1:0]       area;
`ifdef BLOB_CENTROID_EN
    logic [COL_W+AREA_W-1:0] sumx;
    logic [ROW_W+AREA_W-1:0] sumy;
`endif
  } ent_t;

  function automatic logic [AREA_W-1:0] sat_inc(input logic [AREA_W-1:0] a);
    return (&a) ? a : a + AREA_W'(1);
  endfunction

  function automatic ent_t ent_update(input ent_t e, input logic hit,
                                      input logic [COL_W-1:0] c, input logic [ROW_W-1:0] r);
    ent_t n;
    if (!hit) begin
      n.xmin = c;
      n.xmax = c;
      n.ymin = r;
      n.ymax = r;
      n.area = AREA_W'(1);
`ifdef BLOB_CENTROID_EN
      n.sumx = (COL_W+AREA_W)'(c);
      n.sumy = (ROW_W+AREA_W)'(r);
`endif
    end else begin
      n.xmin = (c < e.xmin) ? c : e.xmin;
      n.xmax = (c > e.xmax) ? c : e.xmax;
      n.ymin = (r < e.ymin) ? r : e.ymin;
      n.ymax = (r > e.ymax) ? r : e.ymax;
      n.area = sat_inc(e.area);
`ifdef BLOB_CENTROID_EN
      n.sumx = e.sumx + (COL_W+AREA_W)'(c);
      n.sumy = e.sumy + (ROW_W+AREA_W)'(r);
`endif
    end
    return n;
  endfunction

  state_t               state_q, state_d;
  logic                 fv_prev_q, dv_prev_q;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 flush_cnt_q, flush_cnt_d;
  logic [NLBL-1:0]      vbit_q, vbit_d;
  ent_t                 tbl_q [NLBL];
  logic                 vld_p1_q, vld_p1_d;
  logic [LABEL_W-1:0]   lbl_p1_q, lbl_p1_d;
  logic [COL_W-1:0]     col_p1_q, col_p1_d;
  logic [ROW_W-1:0]     row_p1_q, row_p1_d;
  logic                 hit_p1_q, hit_p1_d;
  ent_t                 ent_p1_q, ent_p1_d;
  ent_t                 upd_ent;
  logic [LABEL_W:0]     scan_idx_q, scan_idx_d;
  logic                 nxt_found;
  logic [LABEL_W-1:0]   nxt_idx;
  logic                 out_valid_q, out_valid_d;
  logic [LABEL_W-1:0]   out_label_q, out_label_d;
  ent_t                 out_ent_q, out_ent_d;
  logic                 err_q, err_d;
  logic                 fv_rise, dv_fall, pix_vld_p0, fwd, slot_free, vbit_clr;

  assign fv_rise    = frame_valid & ~fv_prev_q;
  assign dv_fall    = ~data_valid & dv_prev_q & frame_valid;
  assign pix_vld_p0 = (state_q == ACCUM) && frame_valid && data_valid && (labelin != '0);
  assign fwd        = vld_p1_q && (lbl_p1_q == labelin);
  assign upd_ent    = ent_update(ent_p1_q, hit_p1_q, col_p1_q, row_p1_q);
  assign slot_free  = !out_valid_q || out_ready;
  assign vbit_clr   = (state_q == IDLE) && fv_rise;

  // Pixel coordinate tracking from frame/line strobes
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (fv_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (dv_fall) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end else if (frame_valid && data_valid) begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Stage 1: read entry, taking the in-flight stage-2 result for a back-to-back label
  always_comb begin
    vld_p1_d = pix_vld_p0;
    lbl_p1_d = labelin;
    col_p1_d = col_q;
    row_p1_d = row_q;
    hit_p1_d = fwd | vbit_q[labelin];
    ent_p1_d = fwd ? upd_ent : tbl_q[labelin];
  end

  // Label-valid bits: bulk clear at frame start, set on each stage-2 write
  always_comb begin
    vbit_d = vbit_q;
    if (vbit_clr) vbit_d = '0;
    if (vld_p1_q) vbit_d[lbl_p1_q] = 1'b1;
  end

  // Lowest valid label at or above the readout scan pointer
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NLBL - 1; i >= 1; i--) begin
      if (vbit_q[i] && ((LABEL_W+1)'(i) >= scan_idx_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = LABEL_W'(i);
      end
    end
  end

  // Control FSM next state and output record loading
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    scan_idx_d  = scan_idx_q;
    out_valid_d = out_valid_q && !out_ready;
    out_label_d = out_label_q;
    out_ent_d   = out_ent_q;
    err_d       = fv_rise && (state_q inside {FLUSH, READOUT, DONE});
    case (state_q)
      IDLE:  if (fv_rise) state_d = ACCUM;
      ACCUM: if (!frame_valid) begin
        state_d     = FLUSH;
        flush_cnt_d = 1'b0;
      end
      FLUSH: begin
        flush_cnt_d = 1'b1;
        if (flush_cnt_q) begin
          state_d    = READOUT;
          scan_idx_d = (LABEL_W+1)'(1);
        end
      end
      READOUT: if (slot_free) begin
        if (nxt_found) begin
          out_valid_d = 1'b1;
          out_label_d = nxt_idx;
          out_ent_d   = tbl_q[nxt_idx];
          scan_idx_d  = (LABEL_W+1)'(nxt_idx) + (LABEL_W+1)'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fv_prev_q   <= 1'b0;
      dv_prev_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= 1'b0;
      vbit_q      <= '0;
      vld_p1_q    <= 1'b0;
      scan_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_label_q <= '0;
      out_ent_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fv_prev_q   <= frame_valid;
      dv_prev_q   <= data_valid;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_cnt_q <= flush_cnt_d;
      vbit_q      <= vbit_d;
      vld_p1_q    <= vld_p1_d;
      scan_idx_q  <= scan_idx_d;
      out_valid_q <= out_valid_d;
      out_label_q <= out_label_d;
      out_ent_q   <= out_ent_d;
      err_q       <= err_d;
    end
  end

  // Stage 1 -> stage 2 pipeline data
  always_ff @(posedge clk) begin
    lbl_p1_q <= lbl_p1_d;
    col_p1_q <= col_p1_d;
    row_p1_q <= row_p1_d;
    hit_p1_q <= hit_p1_d;
    ent_p1_q <= ent_p1_d;
  end

  // Stage 2: write the updated entry back to the feature table
  always_ff @(posedge clk) begin
    if (vld_p1_q) tbl_q[lbl_p1_q] <= upd_ent;
  end

  assign out_valid   = out_valid_q;
  assign out_label   = out_label_q;
  assign out_xmin    = out_ent_q.xmin;
  assign out_xmax    = out_ent_q.xmax;
  assign out_ymin    = out_ent_q.ymin;
  assign out_ymax    = out_ent_q.ymax;
  assign out_area    = out_ent_q.area;
`ifdef BLOB_CENTROID_EN
  assign out_sumx    = out_ent_q.sumx;
  assign out_sumy    = out_ent_q.sumy;
`else
  assign out_sumx    = '0;
  assign out_sumy    = '0;
`endif
  assign frame_done  = (state_q == DONE);
  assign err_overrun = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_blob_feature_accum.sv
// Scoreboard bench for blob_feature_accum: frames are described as label
// arrays, expected records come from a per-label min/max/count model.
module tb_blob_feature_accum;
  localparam int LW = 8;
  localparam int CW = 14;
  localparam int RW = 12;
  localparam int AW = 26;
`ifdef BLOB_CENTROID_EN
  localparam bit CENT = 1'b1;
`else
  localparam bit CENT = 1'b0;
`endif

  logic              clk, reset_n, frame_valid, data_valid, out_ready;
  logic [LW-1:0]     labelin;
  logic              out_valid, frame_done, err_overrun, busy;
  logic [LW-1:0]     out_label;
  logic [CW-1:0]     out_xmin, out_xmax;
  logic [RW-1:0]     out_ymin, out_ymax;
  logic [AW-1:0]     out_area;
  logic [CW+AW-1:0]  out_sumx;
  logic [RW+AW-1:0]  out_sumy;

  blob_feature_accum dut (
    .clk(clk), .reset_n(reset_n), .labelin(labelin), .frame_valid(frame_valid),
    .data_valid(data_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_xmin(out_xmin), .out_xmax(out_xmax),
    .out_ymin(out_ymin), .out_ymax(out_ymax), .out_area(out_area),
    .out_sumx(out_sumx), .out_sumy(out_sumy), .frame_done(frame_done),
    .err_overrun(err_overrun), .busy(busy)
  );

  typedef struct packed {
    logic [LW-1:0]    label;
    logic [CW-1:0]    xmin;
    logic [CW-1:0]    xmax;
    logic [RW-1:0]    ymin;
    logic [RW-1:0]    ymax;
    logic [AW-1:0]    area;
    logic [CW+AW-1:0] sumx;
    logic [RW+AW-1:0] sumy;
  } rec_t;

  rec_t exp_q[$];
  int   pix[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, done_cnt = 0, err_cnt = 0;
  int   ready_mode = 0, stall_cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the frame's label array and gather per-label extents.
  task automatic push_model(input int w, input int h);
    bit    seen[256];
    int    xmn[256], xmx[256], ymn[256], ymx[256], ar[256];
    longint sx[256], sy[256];
    rec_t  r;
    for (int l = 0; l < 256; l++) begin
      seen[l] = 0; ar[l] = 0; sx[l] = 0; sy[l] = 0;
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int l;
        l = pix[y*w + x];
        if (l != 0) begin
          if (!seen[l]) begin
            seen[l] = 1; xmn[l] = x; xmx[l] = x; ymn[l] = y; ymx[l] = y;
          end else begin
            if (x < xmn[l]) xmn[l] = x;
            if (x > xmx[l]) xmx[l] = x;
            if (y < ymn[l]) ymn[l] = y;
            if (y > ymx[l]) ymx[l] = y;
          end
          ar[l]++;
          sx[l] += x;
          sy[l] += y;
        end
      end
    end
    for (int l = 1; l < 256; l++) begin
      if (seen[l]) begin
        r.label = LW'(l);
        r.xmin  = CW'(xmn[l]);
        r.xmax  = CW'(xmx[l]);
        r.ymin  = RW'(ymn[l]);
        r.ymax  = RW'(ymx[l]);
        r.area  = AW'(ar[l]);
        r.sumx  = CENT ? (CW+AW)'(sx[l]) : '0;
        r.sumy  = CENT ? (RW+AW)'(sy[l]) : '0;
        exp_q.push_back(r);
      end
    end
  endtask

  // Called just after a rising edge; one-cycle blanking between lines.
  task automatic drive_frame(input int w, input int h, input bit mdl);
    if (mdl) push_model(w, h);
    frame_valid = 1; data_valid = 0;
    @(posedge clk); #1;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        data_valid = 1;
        labelin = LW'(pix[y*w + x]);
        @(posedge clk); #1;
      end
      data_valid = 0;
      labelin = LW'($urandom);
      @(posedge clk); #1;
    end
    frame_valid = 0;
    labelin = 0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_seen", done_cnt != start, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_once", done_cnt, start + 1);
    chk("records_drained", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int w, input int h);
    int start;
    start = done_cnt;
    drive_frame(w, h, 1);
    wait_done(start);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, out_valid, 1);
  endtask

  task automatic rand_pix(input int w, input int h, input bit wide);
    int pool[7];
    pool = '{0, 1, 2, 3, 7, 200, 255};
    pix.delete();
    for (int i = 0; i < w*h; i++)
      pix.push_back(wide ? int'($urandom_range(0, 255)) : pool[$urandom_range(0, 6)]);
  endtask

  // out_ready: 0 always ready, 1 random, 2 hold first record 5 cycles, 3 never ready
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (out_valid && stall_cnt < 5) begin
             out_ready = 0;
             stall_cnt++;
           end else out_ready = 1;
        default: out_ready = 0;
      endcase
    end
  end

  // Monitor: pop and compare on every transfer, check holds and frame_done timing
  initial begin
    rec_t got, prev, e;
    bit   prev_stall, prev_done, had_rec;
    int   last_xfer;
    prev_stall = 0; prev_done = 0; had_rec = 0; last_xfer = 0;
    forever begin
      @(negedge clk);
      got.label = out_label; got.xmin = out_xmin; got.xmax = out_xmax;
      got.ymin = out_ymin; got.ymax = out_ymax; got.area = out_area;
      got.sumx = out_sumx; got.sumy = out_sumy;
      if (!reset_n) begin
        prev_stall = 0; prev_done = 0; had_rec = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          checks++;
          if (got !== prev) begin
            errors++;
            $display("FAIL hold_record: got %h required %h", got, prev);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got label %0d, required no record", out_label);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL record: got lbl=%0d x=%0d..%0d y=%0d..%0d area=%0d sx=%0d sy=%0d required lbl=%0d x=%0d..%0d y=%0d..%0d area=%0d sx=%0d sy=%0d",
                       got.label, got.xmin, got.xmax, got.ymin, got.ymax, got.area, got.sumx, got.sumy,
                       e.label, e.xmin, e.xmax, e.ymin, e.ymax, e.area, e.sumx, e.sumy);
            end
          end
          last_xfer = cyc;
          had_rec = 1;
        end
        if (prev_done) begin
          chk("frame_done_width", frame_done, 0);
          chk("busy_after_done", busy, 0);
        end
        if (frame_done) begin
          done_cnt++;
          if (had_rec) chk("done_latency", cyc, last_xfer + 1);
          had_rec = 0;
        end
        if (err_overrun) err_cnt++;
        prev_done  = frame_done;
        prev_stall = out_valid && !out_ready;
        prev       = got;
      end
    end
  end

  initial begin
    int start;
    reset_n = 0; frame_valid = 0; data_valid = 0; labelin = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_label", out_label, 0);
    chk("rst_out_area", out_area, 0);
    chk("rst_out_xmax", out_xmax, 0);
    chk("rst_out_sumx", out_sumx, 0);
    reset_n = 1;
    @(posedge clk); #1;

    // 4x3 frame of label 5
    ready_mode = 0;
    pix.delete();
    for (int i = 0; i < 12; i++) pix.push_back(5);
    run_frame(4, 3);

    // two labels across two rows
    pix = '{1, 1, 2, 2, 2, 0, 0, 1};
    run_frame(4, 2);

    // alternating labels in a single line
    pix = '{3, 3, 4, 3, 4};
    run_frame(5, 1);

    // consumer stalls on the first record
    stall_cnt = 0;
    ready_mode = 2;
    rand_pix(6, 4, 0);
    run_frame(6, 4);
    ready_mode = 0;

    // frame starts while readout is stalled: dropped and flagged
    ready_mode = 3;
    pix = '{1, 2, 2, 1, 0, 6, 6, 0};
    start = done_cnt;
    drive_frame(4, 2, 1);
    wait_out_valid("overrun_readout_reached");
    pix = '{9, 9, 1, 6, 9, 200};
    drive_frame(3, 2, 0);
    ready_mode = 0;
    wait_done(start);
    chk("overrun_pulses", err_cnt, 1);
    pix = '{8, 0, 8, 8};
    run_frame(2, 2);

    // empty frame
    pix = '{0, 0, 0, 0, 0, 0};
    run_frame(3, 2);

    // randomized frames with random back-pressure, stray pixels outside frames
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      int w, h;
      w = $urandom_range(1, 16);
      h = $urandom_range(1, 6);
      data_valid = 1; labelin = 8'd9;
      repeat (2) @(posedge clk);
      #1;
      data_valid = 0; labelin = 0;
      @(posedge clk); #1;
      rand_pix(w, h, f[0]);
      run_frame(w, h);
    end

    // reset during readout discards the pending frame
    ready_mode = 3;
    rand_pix(5, 3, 1);
    pix[0] = 17;
    drive_frame(5, 3, 1);
    wait_out_valid("reset_readout_reached");
    reset_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_label", out_label, 0);
    chk("midrst_out_area", out_area, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1;
    ready_mode = 0;
    @(posedge clk); #1;
    rand_pix(7, 3, 0);
    run_frame(7, 3);

    chk("overrun_total", err_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/blob_feature_accum.md
Name: blob_feature_accum

Overview:
- Downstream consumer of the CCL second pass (resolved-label stage).
- Takes the resolved label stream (one label per pixel, 0 = background) and accumulates per-label bounding box and area over one frame.
- After frame end, streams one feature record per present label through a valid/ready handshake toward the DMA/feature writer.

Parameters:
- LABEL_W, 8, label width; labels 1..2^LABEL_W-1 tracked.
- COL_W, 14, column counter width.
- ROW_W, 12, row counter width.
- AREA_W, 26, area counter width (COL_W+ROW_W).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- labelin  in  LABEL_W  resolved label of current pixel
- frame_valid  in  1  high during a frame
- data_valid  in  1  labelin valid this cycle (high during line active pixels)
- out_valid  out  1  feature record valid
- out_ready  in  1  consumer accepts record
- out_label  out  LABEL_W  label of record
- out_xmin  out  COL_W  minimum column
- out_xmax  out  COL_W  maximum column
- out_ymin  out  ROW_W  minimum row
- out_ymax  out  ROW_W  maximum row
- out_area  out  AREA_W  pixel count
- out_sumx  out  COL_W+AREA_W  sum of columns (optional feature)
- out_sumy  out  ROW_W+AREA_W  sum of rows (optional feature)
- frame_done  out  1  one-cycle pulse after the last record of a frame is accepted
- err_overrun  out  1  one-cycle pulse when a frame starts during readout
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: every output 0, state IDLE, all label-valid bits cleared, col/row counters 0.
- Coordinates:
  - col increments on each accepted pixel (data_valid && frame_valid).
  - On data_valid falling edge while frame_valid: col <- 0, row <- row+1.
  - On frame_valid rising edge: col <- 0, row <- 0.
  - Counters wrap silently at their widths.
- States:
  - IDLE: on frame_valid rise, clear all 2^LABEL_W valid bits in one cycle, go to ACCUM.
  - ACCUM: pixels with label != 0 enter a 2-stage read-modify-write pipeline.
    - Stage 1 reads the entry.
    - Stage 2 updates and writes it.
    - The update is visible in the table 2 cycles after input.
    - On frame_valid fall, go to FLUSH.
  - FLUSH: 2 cycles to drain the pipeline, then go to READOUT.
  - READOUT: scan index 1..2^LABEL_W-1 ascending, skipping entries whose valid bit is 0. Valid entries are read with 1-cycle table latency into the output register. After the last index is accepted, go to DONE.
  - DONE: pulse frame_done for 1 cycle, go to IDLE.
- Per-entry update:
  - First pixel of a label (valid bit 0): xmin = xmax = col, ymin = ymax = row, area = 1, set valid bit.
  - Otherwise: min/max compare and area+1. Area saturates at all-ones.
- Hazard: consecutive pixels with the same label (back-to-back or 1 apart) must be forwarded from stage 2/write data. The result must equal sequential processing, with no stalls.
- Label 0 and pixels with data_valid && !frame_valid are ignored.
- Output handshake:
  - Record is held stable while out_valid && !out_ready.
  - Transfer happens on out_valid && out_ready.
  - out_valid may rise in the cycle after transfer if the next valid entry is ready.
  - No records are emitted if no label was seen; frame_done still pulses after FLUSH.
- Overrun: frame_valid rise in FLUSH/READOUT/DONE:
  - pulse err_overrun;
  - that entire frame is dropped;
  - accumulation restarts only on the next frame_valid rise seen in IDLE;
  - readout of the current frame completes normally.
- Reset mid-operation: immediate return to reset values; any partial record is discarded.

Optional Feature:
- Macro BLOB_CENTROID_EN.
- Defined: each entry also accumulates sumx += col and sumy += row (wrap at width), output on out_sumx/out_sumy with the record, forwarded like the other fields.
- Undefined: no sum storage is implemented; out_sumx and out_sumy are driven constant 0.

Test Plan:
- 4x3 frame, all pixels label 5 -> one record: label 5, x 0..3, y 0..2, area 12; frame_done 1 cycle after accept. With BLOB_CENTROID_EN: sumx 18, sumy 12.
- Row 0 labels 1,1,2,2; row 1 labels 2,0,0,1 -> records in order: label 1 (x0..3, y0..1, area 3), then label 2 (x0..3, y0..1, area 3).
- Back-to-back alternating labels 3,3,4,3,4 in one line -> label 3 area 3, xmin 0, xmax 3; label 4 area 2, xmin 2, xmax 4 (checks forwarding).
- out_ready held low 5 cycles during readout -> record fields stable, no record lost or duplicated, count matches.
- frame_valid rises during READOUT -> err_overrun pulse, current records complete; that frame yields no records; the next frame is processed normally.
- All-zero frame -> no out_valid; frame_done pulses once; busy drops to 0 the cycle after.
